// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO and programmable baud divider.
// Registers: TXDATA (0x00), TXCTRL (0x08), DIV (0x18); read data is returned one cycle after the strobe.
module uart_tx_periph #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd433
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reg_valid,
    input  logic        reg_we,
    input  logic [4:0]  reg_addr,
    input  logic [31:0] reg_wdata,
    output logic [31:0] reg_rdata,
    output logic        txd,
    output logic        tx_busy
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
    localparam logic [2:0]    IDX_TXDATA = 3'd0;
    localparam logic [2:0]    IDX_TXCTRL = 3'd2;
    localparam logic [2:0]    IDX_DIV    = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_e;

    logic [7:0]    fifo_mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          txen_q, txen_d;
    logic [15:0]   div_q, div_d;
    logic [31:0]   rdata_q, rdata_d;
    state_e        state_q, state_d;
    logic [15:0]   baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d, busy_q, busy_d;
    logic          wr_s, rd_s, push_s, push_ok_s, pop_s, full_s, empty_s, bit_end_s;
    logic [2:0]    idx_s;
    logic          unused_s;

    assign unused_s  = ^{reg_addr[1:0], reg_wdata[31:16]};
    assign idx_s     = reg_addr[4:2];
    assign wr_s      = reg_valid & reg_we;
    assign rd_s      = reg_valid & ~reg_we;
    assign full_s    = (count_q == DEPTH_C);
    assign empty_s   = (count_q == {CW{1'b0}});
    assign push_s    = wr_s & (idx_s == IDX_TXDATA);
    // A pop in the same cycle frees a slot, so a push into a full FIFO is still taken.
    assign push_ok_s = push_s & (~full_s | pop_s);
    // >= keeps a DIV lowered mid-bit from stretching the bit through a full counter wrap.
    assign bit_end_s = (baud_q >= div_q);

    // Control register writes and registered read data.
    always_comb begin
        txen_d  = txen_q;
        div_d   = div_q;
        rdata_d = rdata_q;
        if (wr_s) begin
            case (idx_s)
                IDX_TXCTRL: txen_d = reg_wdata[0];
                IDX_DIV:    div_d  = reg_wdata[15:0];
                default:    txen_d = txen_q;
            endcase
        end else if (rd_s) begin
            case (idx_s)
                IDX_TXDATA: rdata_d = {full_s, 31'd0};
                IDX_TXCTRL: rdata_d = {31'd0, txen_q};
                IDX_DIV:    rdata_d = {16'd0, div_q};
                default:    rdata_d = 32'd0;
            endcase
        end else begin
            rdata_d = rdata_q;
        end
    end

    // FIFO pointer and occupancy update.
    always_comb begin
        wr_ptr_d = push_ok_s ? (wr_ptr_q + PW'(1'b1)) : wr_ptr_q;
        rd_ptr_d = pop_s ? (rd_ptr_q + PW'(1'b1)) : rd_ptr_q;
        case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + CW'(1'b1);
            2'b01:   count_d = count_q - CW'(1'b1);
            default: count_d = count_q;
        endcase
    end

    // Frame sequencer: next state, baud/bit counters, pops and the next txd level.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop_s   = 1'b0;
        case (state_q)
            S_IDLE: begin
                baud_d = 16'd0;
                bit_d  = 3'd0;
                if (txen_q && !empty_s) begin
                    pop_s   = 1'b1;
                    shift_d = fifo_mem_q[rd_ptr_q];
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (bit_end_s) begin
                    baud_d  = 16'd0;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            S_DATA: begin
                if (bit_end_s) begin
                    baud_d = 16'd0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            S_STOP: begin
                if (bit_end_s) begin
                    baud_d = 16'd0;
                    bit_d  = 3'd0;
                    // Chain straight into the next start bit so queued bytes go out gapless.
                    if (txen_q && !empty_s) begin
                        pop_s   = 1'b1;
                        shift_d = fifo_mem_q[rd_ptr_q];
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        case (state_d)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = shift_d[bit_d];
            default: txd_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE) | (count_d != {CW{1'b0}});
    end

    // FIFO storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= 8'd0;
            end
        end else if (push_ok_s) begin
            fifo_mem_q[wr_ptr_q] <= reg_wdata[7:0];
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
            txen_q   <= 1'b0;
            div_q    <= DIV_RESET;
            rdata_q  <= 32'd0;
            state_q  <= S_IDLE;
            baud_q   <= 16'd0;
            bit_q    <= 3'd0;
            shift_q  <= 8'd0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            txen_q   <= txen_d;
            div_q    <= div_d;
            rdata_q  <= rdata_d;
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            txd_q    <= txd_d;
            busy_q   <= busy_d;
        end
    end

    assign reg_rdata = rdata_q;
    assign txd       = txd_q;
    assign tx_busy   = busy_q;
endmodule

// File: tb/tb_uart_tx_periph.sv
// Randomised bench for uart_tx_periph: a serial receiver decodes txd and matches each
// frame against a queue of bytes the bus model says were accepted.
module tb_uart_tx_periph;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        reg_valid, reg_we;
    logic [4:0]  reg_addr;
    logic [31:0] reg_wdata, reg_rdata;
    logic        txd, tx_busy;

    int          n_vec = 0;
    int          n_err = 0;
    int unsigned cyc = 0;
    int unsigned last_wcyc, idle_cyc;
    int          mon_div;
    bit          mon_on;
    logic [7:0]  exp_q[$];
    int unsigned starts[$];
    int          mon_glitch;
    logic [9:0]  mon_bits;
    logic [7:0]  mon_byte;
    logic [31:0] rv;
    logic [7:0]  hello [7] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h21, 8'h0A};

    uart_tx_periph dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .reg_valid (reg_valid),
        .reg_we    (reg_we),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .txd       (txd),
        .tx_busy   (tx_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        reg_valid = 1'b1; reg_we = 1'b1; reg_addr = a; reg_wdata = d;
        @(posedge clk); #1;
        reg_valid = 1'b0; reg_we = 1'b0;
        last_wcyc = cyc;
    endtask

    task automatic bus_rd(input logic [4:0] a, output logic [31:0] d);
        @(negedge clk);
        reg_valid = 1'b1; reg_we = 1'b0; reg_addr = a;
        @(posedge clk); #1;
        reg_valid = 1'b0;
        d = reg_rdata;
    endtask

    task automatic set_div(input int d);
        logic [31:0] r;
        bus_wr(5'h18, 32'(d));
        mon_div = d;
        bus_rd(5'h18, r);
        check_eq("div_readback", r, 32'(d));
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx_busy !== 1'b0 && n < 20000);
        check_eq("idle_timeout", 32'(n < 20000), 32'd1);
        idle_cyc = cyc;
        if (starts.size() > 0)
            check_eq("busy_fall", idle_cyc, starts[$] + 32'(10 * (mon_div + 1)));
        repeat (2) @(negedge clk);
        check_eq("drain", 32'(exp_q.size()), 32'd0);
    endtask

    // Serial receiver: every clock of each bit must hold the same level.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_on && rst_n && txd === 1'b0) begin
                starts.push_back(cyc);
                mon_glitch = 0;
                for (int b = 0; b < 10; b++) begin
                    for (int c = 0; c <= mon_div; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (c == 0) mon_bits[b] = txd;
                        else if (txd !== mon_bits[b]) mon_glitch++;
                    end
                end
                mon_byte = mon_bits[8:1];
                check_eq("bit_stable", 32'(mon_glitch), 32'd0);
                check_eq("start_bit", 32'(mon_bits[0]), 32'd0);
                check_eq("stop_bit", 32'(mon_bits[9]), 32'd1);
                if (exp_q.size() == 0) check_eq("extra_frame", 32'(mon_byte), 32'hFFFF_FFFF);
                else check_eq("rx_byte", 32'(mon_byte), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        int n, d, en_first;
        logic [7:0] b, b2;
        rst_n = 1'b0; reg_valid = 1'b0; reg_we = 1'b0; reg_addr = 5'd0; reg_wdata = 32'd0;
        mon_on = 1'b0; mon_div = 433;
        repeat (3) @(negedge clk);
        check_eq("rst_txd", 32'(txd), 32'd1);
        check_eq("rst_busy", 32'(tx_busy), 32'd0);
        check_eq("rst_rdata", reg_rdata, 32'd0);
        rst_n = 1'b1;
        bus_rd(5'h18, rv); check_eq("div_reset", rv, 32'd433);
        bus_rd(5'h08, rv); check_eq("txen_reset", rv, 32'd0);
        bus_rd(5'h00, rv); check_eq("txdata_empty", rv, 32'd0);
        bus_wr(5'h10, $urandom); bus_rd(5'h10, rv); check_eq("unmapped_rd", rv, 32'd0);
        mon_on = 1'b1;

        // Single byte 0x41 at DIV=3, including write-to-start-bit latency.
        set_div(3);
        bus_wr(5'h08, 32'hFFFF_FFFF);
        bus_rd(5'h08, rv); check_eq("txen_rd", rv, 32'd1);
        starts.delete(); exp_q.push_back(8'h41);
        bus_wr(5'h00, 32'h41);
        wait_idle();
        check_eq("start_latency", starts[0], last_wcyc + 1);

        // "Hello!\n" back to back at DIV=0: frames must be exactly 10 clocks apart.
        set_div(0); starts.delete();
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(hello[i]);
            bus_wr(5'h00, {24'hABCDEF, hello[i]});
        end
        wait_idle();
        check_eq("hello_frames", 32'(starts.size()), 32'd7);
        for (int i = 1; i < starts.size(); i++)
            check_eq("gapless", starts[i] - starts[i-1], 32'd10);

        // Overfill while disabled: the ninth byte is dropped.
        bus_wr(5'h08, 32'd0); set_div(1); starts.delete();
        for (int i = 0; i < 9; i++) begin
            bus_wr(5'h00, 32'h30 + 32'(i));
            if (i < 8) exp_q.push_back(8'h30 + 8'(i));
        end
        bus_rd(5'h00, rv); check_eq("full_flag", rv, 32'h8000_0000);
        bus_wr(5'h08, 32'd1);
        wait_idle();
        check_eq("overfill_frames", 32'(starts.size()), 32'd8);

        // Push into a full FIFO in the very cycle the first pop happens.
        bus_wr(5'h08, 32'd0); starts.delete();
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            bus_wr(5'h00, 32'(b));
        end
        exp_q.push_back(8'h55);
        bus_wr(5'h08, 32'd1);
        bus_wr(5'h00, 32'h55);
        bus_rd(5'h00, rv); check_eq("full_after_swap", rv, 32'h8000_0000);
        wait_idle();
        check_eq("swap_frames", 32'(starts.size()), 32'd9);

        // Disable during data bit 3: the frame completes, the next byte waits.
        set_div(2); starts.delete();
        b = 8'($urandom); b2 = 8'($urandom);
        exp_q.push_back(b);
        bus_wr(5'h00, 32'(b));
        bus_wr(5'h00, 32'(b2));
        n = 0;
        while (starts.size() == 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_eq("start_timeout", 32'(n < 1000), 32'd1);
        repeat (12) @(negedge clk);
        bus_wr(5'h08, 32'd0);
        repeat (40) @(negedge clk);
        check_eq("txen_off_done", 32'(exp_q.size()), 32'd0);
        check_eq("txen_off_nopop", 32'(starts.size()), 32'd1);
        check_eq("txen_off_txd", 32'(txd), 32'd1);
        check_eq("txen_off_busy", 32'(tx_busy), 32'd1);
        exp_q.push_back(b2);
        bus_wr(5'h08, 32'd1);
        wait_idle();
        check_eq("resume_frames", 32'(starts.size()), 32'd2);

        // Randomised bursts: random divider, length, byte values and enable order.
        for (int it = 0; it < 6; it++) begin
            d = $urandom_range(0, 4);
            n = $urandom_range(1, 8);
            en_first = $urandom_range(0, 1);
            set_div(d);
            bus_wr(5'h08, 32'(en_first));
            starts.delete();
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                exp_q.push_back(b);
                bus_wr(5'h00, 32'(b));
            end
            if (en_first == 0) bus_wr(5'h08, 32'd1);
            wait_idle();
            check_eq("rand_frames", 32'(starts.size()), 32'(n));
        end

        // Asynchronous reset in the middle of a frame.
        mon_on = 1'b0;
        set_div(3);
        bus_wr(5'h00, 32'hA5);
        repeat (15) @(negedge clk);
        check_eq("midframe_busy", 32'(tx_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("arst_txd", 32'(txd), 32'd1);
        check_eq("arst_busy", 32'(tx_busy), 32'd0);
        check_eq("arst_rdata", reg_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus_rd(5'h18, rv); check_eq("arst_div", rv, 32'd433);
        bus_rd(5'h08, rv); check_eq("arst_txen", rv, 32'd0);
        bus_rd(5'h00, rv); check_eq("arst_fifo", rv, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
